// File: rtl/log2_pkg.sv
// Shared types and constants for the iterative log2 unit.
// The optional rounding mode is selected by the LOG2_ROUND_EN macro
// (see log2_norm_iter.sv); nothing in this package depends on it.
package log2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    FRAC = 2'd2,
    OUT  = 2'd3
  } state_e;

  localparam int W_DEF = 16;
  localparam int F_DEF = 8;
  localparam int M_DEF = 16;

  // Ceiling log2, never less than 1 so that derived widths stay legal.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        r = r + 1;
        v = v >> 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/log2_square_trunc.sv
// Squares a Q1.M mantissa and keeps the Q2.M window of the product.
// Kept separate so the multiplier can later be pipelined or mapped to a DSP.
module log2_square_trunc #(
  parameter int M = 16
) (
  input  logic [M:0]   m_i,
  output logic [M+1:0] t_o
);

  logic [2*M+1:0] prod;

  // Full-width square, then drop the M low fraction bits (truncation).
  always_comb begin
    prod = {{(M+1){1'b0}}, m_i} * {{(M+1){1'b0}}, m_i};
    t_o  = (M+2)'(prod >> M);
  end

endmodule

// File: rtl/log2_norm_iter.sv
// Iterative fixed-point log2: leading-zero normalisation gives the integer
// part, repeated squaring of the mantissa gives one fraction bit per cycle.
// Define LOG2_ROUND_EN to run one extra iteration and round half-up
// (saturating at all-ones) instead of truncating.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// NORM  | shifting zr left until its MSB is set (or detecting zero)
// FRAC  | one squaring step per cycle, fraction bit shifted into y_frac
// OUT   | result held with out_valid high until out_ready
module log2_norm_iter
  import log2_pkg::*;
#(
  parameter  int W  = W_DEF,
  parameter  int F  = F_DEF,
  parameter  int M  = M_DEF,
  localparam int IW = clog2(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] y_int,
  output logic [F-1:0]  y_frac,
  output logic          err_zero
);

`ifdef LOG2_ROUND_EN
  localparam int NIT = F + 1;
`else
  localparam int NIT = F;
`endif
  localparam int CW = clog2(NIT + 1);

  state_e        state_q;
  logic [W-1:0]  zr_q;
  logic [IW-1:0] lz_q;
  logic [M:0]    m_q;
  logic [CW-1:0] it_q;
  logic [IW-1:0] y_int_q;
  logic [F-1:0]  y_frac_q;
  logic          err_zero_q;
  logic          out_valid_q;
  logic          in_ready_q;

  logic [M:0]    mant_load;
  logic [M+1:0]  t_sq;

  // Left-align the normalised operand into the Q1.M mantissa.
  generate
    if (W - 1 < M) begin : g_pad
      assign mant_load = {zr_q, {(M + 1 - W){1'b0}}};
    end else begin : g_trunc
      assign mant_load = zr_q[W-1 -: M+1];
    end
  endgenerate

  log2_square_trunc #(.M(M)) u_sq (
    .m_i (m_q),
    .t_o (t_sq)
  );

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      zr_q        <= '0;
      lz_q        <= '0;
      m_q         <= '0;
      it_q        <= '0;
      y_int_q     <= '0;
      y_frac_q    <= '0;
      err_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            zr_q       <= x;
            lz_q       <= '0;
            y_int_q    <= '0;
            y_frac_q   <= '0;
            err_zero_q <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= NORM;
          end
        end
        NORM: begin
          if (zr_q == '0) begin
            err_zero_q  <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end else if (zr_q[W-1]) begin
            y_int_q <= IW'(W - 1) - lz_q;
            m_q     <= mant_load;
            it_q    <= '0;
            state_q <= FRAC;
          end else begin
            zr_q <= zr_q << 1;
            lz_q <= lz_q + IW'(1);
          end
        end
        FRAC: begin
`ifdef LOG2_ROUND_EN
          // Last pass produces the guard bit: round half-up, saturate.
          if (it_q == CW'(NIT - 1)) begin
            if (!(&y_frac_q)) y_frac_q <= y_frac_q + F'(t_sq[M+1]);
          end else begin
            y_frac_q <= (y_frac_q << 1) | F'(t_sq[M+1]);
          end
`else
          y_frac_q <= (y_frac_q << 1) | F'(t_sq[M+1]);
`endif
          m_q  <= t_sq[M+1] ? t_sq[M+1:1] : t_sq[M:0];
          it_q <= it_q + CW'(1);
          if (it_q == CW'(NIT - 1)) begin
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y_int     = y_int_q;
  assign y_frac    = y_frac_q;
  assign err_zero  = err_zero_q;

endmodule
